tx_buffer: RTL and testbench
============================

// Module: tx_buffer
// PURPOSE
//  Parallel-in, serial-out transmit buffer; mirror of the serial receive buffer on the same link.
//  Accepts one WIDTH-bit parallel word, then shifts it out one bit per consumer strobe, LSB first.
//  Its serial output feeds the receiver's serial input; after WIDTH strobes the receiver holds the original word.
// PARAMETERS
//  WORD_SIZE    8  bits per word
//  NO_OF_WORDS  1  words per buffer; WIDTH = WORD_SIZE*NO_OF_WORDS
// PORTS
//  clk                  in   1      single clock; all state updates on posedge
//  reset                in   1      synchronous, active-high
//  data_parallel_wr_en  in   1      load request; accepted only when buffer_empty=1
//  data_parallel_in     in   WIDTH  word to transmit; sampled on the accepted cycle
//  buffer_empty         out  1      1 = IDLE, a new word may be loaded
//  data_serial_rd_en    in   1      consumer strobe; consumes the current bit
//  data_serial_out      out  1      current bit = shift_reg[0] (or the parity bit, see CONFIGURATION)
//  data_serial_valid    out  1      1 while in SHIFT; data_serial_out is meaningful
//  tx_done              out  1      one-cycle pulse in the cycle after the last bit is consumed
// BEHAVIOUR
//  Reset values: shift_reg=0, bit_cnt=0, state=IDLE.
//   Outputs during reset: buffer_empty=1, data_serial_out=0, data_serial_valid=0, tx_done=0.
//  States: IDLE, SHIFT. state is a 1-bit register.
//  IDLE, wr_en=1: shift_reg<=data_parallel_in; bit_cnt<=NBITS; go to SHIFT.
//   NBITS = WIDTH, or WIDTH+1 with parity.
//  IDLE, rd_en=1: ignored; no state change.
//  SHIFT, rd_en=1 and bit_cnt>1: shift_reg<=shift_reg>>1 (MSB filled with 0); bit_cnt<=bit_cnt-1.
//  SHIFT, rd_en=1 and bit_cnt==1: shift_reg<=0; bit_cnt<=0; go to IDLE; tx_done=1 next cycle.
//  SHIFT, rd_en=0: hold. No timeout; the block waits indefinitely for the consumer.
//  SHIFT, wr_en=1: ignored, with no overwrite and no queueing; the word in flight is preserved.
//  Simultaneous wr_en and last rd_en: the last bit is consumed and the block goes IDLE.
//   That cycle's wr_en is dropped because buffer_empty was 0.
//  Latency: load accepted at edge N; first bit valid from edge N (cycle N+1).
//   Each rd_en edge exposes the next bit in the following cycle.
//  Outputs are registered or decoded directly from registers; no input-to-output combinational path.
//  Counter width: CNT_W = logb2(WIDTH+2).
//   bit_cnt never exceeds NBITS and never underflows, since decrement occurs only when bit_cnt>=1.
//  Reset mid-transfer: the word is discarded and the block returns to IDLE within one edge; tx_done is not pulsed.
// CONFIGURATION
//  Macro TX_BUFFER_PARITY_EN.
//  Defined:
//   - Even parity (^data_parallel_in) is latched into parity_reg at load.
//   - After the WIDTH data bits, one extra serial bit is sent.
//   - data_serial_out = parity_reg when bit_cnt==1.
//   - NBITS = WIDTH+1.
//  Undefined:
//   - No parity register; NBITS = WIDTH.
//   - The serial stream is bit-exact with what the receive buffer expects.
// STRUCTURE
//  Shared package/include holds:
//   - the logb2 function
//   - the state encoding localparams (ST_IDLE=1'b0, ST_SHIFT=1'b1)
//  Both this block and the receive buffer use that shared package/include.
//  No sub-module: state register, shift register and counter are implemented inline (~150 lines).
// TESTING
//  1 Reset: hold reset 3 cycles -> buffer_empty=1, valid=0, out=0, tx_done=0.
//  2 WIDTH=8, load 8'hA5, strobe rd_en every cycle:
//     out sequence 1,0,1,0,0,1,0,1; tx_done pulses once after the 8th strobe; buffer_empty=1.
//  3 Loopback into the receive buffer (serial_wr_en = valid & rd_en), load 8'h3C:
//     receiver buffer_full after 8 strobes; its parallel out = 8'h3C after rd_enable.
//  4 Load 8'hFF, then wr_en with 8'h00 mid-transfer and gapped rd_en:
//     all 8 bits read back as 1; second load ignored.
//  5 Reset asserted after 3 of 8 bits -> IDLE next edge, valid=0, no tx_done; a fresh load of 8'h81 sends cleanly.
//  6 With TX_BUFFER_PARITY_EN, load 8'h07 -> 9 bits 1,1,1,0,0,0,0,0,1 (parity=1); tx_done after the 9th strobe.

Source files
------------

// File: rtl/tx_buffer_pkg.sv
// Shared definitions for the serial link transmit/receive buffers:
// state encoding and the counter-width helper.
package tx_buffer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Number of bits needed to represent value (0 for value==0).
    function automatic int unsigned logb2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/tx_buffer.sv
// Parallel-in, serial-out transmit buffer, LSB first, one bit per consumer strobe.
// Optional even-parity trailer bit enabled by the TX_BUFFER_PARITY_EN macro.
module tx_buffer
    import tx_buffer_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 8,
    parameter int unsigned NO_OF_WORDS = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                data_parallel_wr_en,
    input  logic [WORD_SIZE*NO_OF_WORDS-1:0]    data_parallel_in,
    output logic                                buffer_empty,
    input  logic                                data_serial_rd_en,
    output logic                                data_serial_out,
    output logic                                data_serial_valid,
    output logic                                tx_done
);

    localparam int unsigned WIDTH = WORD_SIZE * NO_OF_WORDS;
`ifdef TX_BUFFER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CNT_W = logb2(WIDTH + 2);

    logic             state;
    logic             state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             load_c;
    logic             consume_c;
    logic             last_bit_c;
`ifdef TX_BUFFER_PARITY_EN
    logic             parity_reg;
`endif

    // A load is only honoured while idle; strobes only count while shifting.
    assign load_c     = (state == ST_IDLE) && data_parallel_wr_en;
    assign consume_c  = (state == ST_SHIFT) && data_serial_rd_en;
    assign last_bit_c = (bit_cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (data_parallel_wr_en) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (data_serial_rd_en && last_bit_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Shift register, bit counter and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= consume_c && last_bit_c;
            if (load_c) begin
                shift_reg <= data_parallel_in;
                bit_cnt   <= CNT_W'(NBITS);
            end else if (consume_c) begin
                if (last_bit_c) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef TX_BUFFER_PARITY_EN
    // Parity of the loaded word, sent after the data bits
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_reg <= 1'b0;
        end else if (load_c) begin
            parity_reg <= ^data_parallel_in;
        end
    end
`endif

    // Outputs decoded straight from registers
    always_comb begin
        buffer_empty      = (state == ST_IDLE);
        data_serial_valid = (state == ST_SHIFT);
`ifdef TX_BUFFER_PARITY_EN
        data_serial_out   = last_bit_c ? parity_reg : shift_reg[0];
`else
        data_serial_out   = shift_reg[0];
`endif
    end

endmodule

// File: tb/tb_tx_buffer.sv
// Directed scoreboard bench for tx_buffer; expected serial bits are queued at load
// and popped as each strobe consumes a bit.
module tb_tx_buffer;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             data_parallel_wr_en;
    logic [WIDTH-1:0] data_parallel_in;
    logic             buffer_empty;
    logic             data_serial_rd_en;
    logic             data_serial_out;
    logic             data_serial_valid;
    logic             tx_done;

    logic             sb[$];
    int               checks;
    int               passed;
    logic [WIDTH-1:0] rx_sr;
    int               rx_cnt;

    tx_buffer #(.WORD_SIZE(8), .NO_OF_WORDS(1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .data_parallel_wr_en (data_parallel_wr_en),
        .data_parallel_in    (data_parallel_in),
        .buffer_empty        (buffer_empty),
        .data_serial_rd_en   (data_serial_rd_en),
        .data_serial_out     (data_serial_out),
        .data_serial_valid   (data_serial_valid),
        .tx_done             (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Push the bits the link should carry for this word, LSB first.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) sb.push_back(w[i]);
`ifdef TX_BUFFER_PARITY_EN
        sb.push_back(^w);
`endif
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        data_parallel_wr_en = 1'b1;
        data_parallel_in    = w;
        push_word(w);
        cycle();
        data_parallel_wr_en = 1'b0;
    endtask

    // Check the current bit; when strobing, consume it and feed the loopback receiver.
    task automatic step(input string tag, input logic strobe);
        logic exp;
        chk({tag, "_valid"}, 32'(data_serial_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = strobe ? sb.pop_front() : sb[0];
            chk(tag, 32'(data_serial_out), 32'(exp));
        end
        if (strobe && data_serial_valid) begin
            rx_sr  = {data_serial_out, rx_sr[WIDTH-1:1]};
            rx_cnt = rx_cnt + 1;
        end
        data_serial_rd_en = strobe;
        cycle();
        data_serial_rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 64) begin
            step(tag, 1'b1);
            guard++;
        end
        chk({tag, "_tx_done"}, 32'(tx_done), 32'd1);
        chk({tag, "_empty"}, 32'(buffer_empty), 32'd1);
        chk({tag, "_valid_end"}, 32'(data_serial_valid), 32'd0);
        cycle();
        chk({tag, "_tx_done_pulse"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        clk                 = 1'b0;
        reset               = 1'b1;
        data_parallel_wr_en = 1'b0;
        data_parallel_in    = '0;
        data_serial_rd_en   = 1'b0;
        checks              = 0;
        passed              = 0;
        rx_sr               = '0;
        rx_cnt              = 0;

        // Reset held for 3 cycles
        @(negedge clk);
        cycle(); cycle(); cycle();
        chk("rst_empty", 32'(buffer_empty), 32'd1);
        chk("rst_valid", 32'(data_serial_valid), 32'd0);
        chk("rst_out", 32'(data_serial_out), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        cycle();

        // Strobe while idle is ignored
        data_serial_rd_en = 1'b1;
        cycle();
        data_serial_rd_en = 1'b0;
        chk("idle_rd_empty", 32'(buffer_empty), 32'd1);
        chk("idle_rd_valid", 32'(data_serial_valid), 32'd0);

        // A5 with a strobe every cycle
        load(8'hA5);
        chk("a5_empty", 32'(buffer_empty), 32'd0);
        drain("a5");

        // Loopback into a receiver model
        rx_sr  = '0;
        rx_cnt = 0;
        load(8'h3C);
        for (int i = 0; i < WIDTH; i++) step("loop", 1'b1);
        chk("loop_rx_full", 32'(rx_cnt), 32'(WIDTH));
        chk("loop_rx_word", 32'(rx_sr), 32'h3C);
`ifdef TX_BUFFER_PARITY_EN
        step("loop_par", 1'b1);
`endif
        chk("loop_tx_done", 32'(tx_done), 32'd1);
        cycle();

        // FF with a mid-transfer overwrite attempt and gapped strobes
        load(8'hFF);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 3) begin
                data_parallel_wr_en = 1'b1;
                data_parallel_in    = 8'h00;
            end
            step("ff_gap", 1'b0);
            data_parallel_wr_en = 1'b0;
            step("ff_bit", 1'b1);
        end
        drain("ff");

        // Load racing the last strobe is dropped
        load(8'h01);
        for (int i = 0; i < int'(WIDTH) - 1; i++) step("race", 1'b1);
`ifdef TX_BUFFER_PARITY_EN
        step("race_pre", 1'b1);
`endif
        data_parallel_wr_en = 1'b1;
        data_parallel_in    = 8'h55;
        step("race_last", 1'b1);
        data_parallel_wr_en = 1'b0;
        chk("race_empty", 32'(buffer_empty), 32'd1);
        chk("race_valid", 32'(data_serial_valid), 32'd0);
        cycle();

        // Reset after 3 bits, then a clean 81
        load(8'hC3);
        for (int i = 0; i < 3; i++) step("mid", 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_empty", 32'(buffer_empty), 32'd1);
        chk("mid_rst_valid", 32'(data_serial_valid), 32'd0);
        chk("mid_rst_tx_done", 32'(tx_done), 32'd0);
        chk("mid_rst_out", 32'(data_serial_out), 32'd0);
        cycle();
        chk("mid_rst_tx_done2", 32'(tx_done), 32'd0);
        load(8'h81);
        drain("x81");

`ifdef TX_BUFFER_PARITY_EN
        // 07 carries a parity bit of 1 after the data bits
        load(8'h07);
        drain("par07");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
